vga_stream_tx: RTL and testbench

- Pixel-side transmitter of the video path: consumes a 24-bit pixel stream (valid/ready, start-of-frame marker) produced on pixel_clk by the SDRAM reader/CDC FIFO.
- Generates the panel timing (sync, data enable) and drives RGB to the HDMI/VGA output pins.
- Detects stream underflow and frame misalignment, then resynchronises on the next start-of-frame without operator action.

---
 rtl/video_pkg.sv | 41 ++++
 rtl/video_timing_gen.sv | 89 ++++++++
 rtl/vga_stream_tx.sv | 167 ++++++++++++++++
 tb/tb_vga_stream_tx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the pixel-side video transmitter.
//   - Default panel timing (800x480 active area, porches and sync widths)
//   - htotal()/vtotal(): total line / frame length from the timing numbers
//   - tx_state_e : stream transmitter state (waiting for start-of-frame or
//                  streaming pixels)
//   - rgb_t      : packed {R[7:0], G[7:0], B[7:0]} pixel
// -----------------------------------------------------------------------------
package video_pkg;

   // Default timing, horizontal values in pixel_clk cycles, vertical in lines
   localparam int H_DISP_DEF   = 800;
   localparam int H_FP_DEF     = 40;
   localparam int H_PULSE_DEF  = 48;
   localparam int H_BP_DEF     = 40;
   localparam int V_DISP_DEF   = 480;
   localparam int V_FP_DEF     = 13;
   localparam int V_PULSE_DEF  = 3;
   localparam int V_BP_DEF     = 29;

   // Total line length: blanking (fp + sync + bp) followed by the active area
   function automatic int htotal(input int fp, input int pulse, input int bp,
                                 input int disp);
      return fp + pulse + bp + disp;
   endfunction

   // Total frame length in lines, same ordering as a line
   function automatic int vtotal(input int fp, input int pulse, input int bp,
                                 input int disp);
      return fp + pulse + bp + disp;
   endfunction

   typedef enum logic {
      WAIT_SOF = 1'b0,
      STREAM   = 1'b1
   } tx_state_e;

   typedef logic [23:0] rgb_t;

endpackage

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Free-running horizontal/vertical position counters and the combinational
// region decode derived from them. Each line (and each frame) is laid out as
// front porch, sync pulse, back porch, then the active area, so the active
// area always ends at the counter wrap.
//
// Ports:
//   pixel_clk    in   pixel clock
//   sys_rst      in   asynchronous active-high reset, counters return to 0
//   hsync_c      out  hcnt inside the horizontal sync pulse (active-high here)
//   vsync_c      out  vcnt inside the vertical sync pulse (active-high here)
//   active_c     out  current position is inside the active picture
//   first_c      out  current position is the first active pixel of the frame
//   frame_origin out  hcnt == 0 and vcnt == 0
// -----------------------------------------------------------------------------
module video_timing_gen
   import video_pkg::*;
#(
   parameter int HDISP  = H_DISP_DEF,
   parameter int HFP    = H_FP_DEF,
   parameter int HPULSE = H_PULSE_DEF,
   parameter int HBP    = H_BP_DEF,
   parameter int VDISP  = V_DISP_DEF,
   parameter int VFP    = V_FP_DEF,
   parameter int VPULSE = V_PULSE_DEF,
   parameter int VBP    = V_BP_DEF
) (
   input  logic pixel_clk,
   input  logic sys_rst,
   output logic hsync_c,
   output logic vsync_c,
   output logic active_c,
   output logic first_c,
   output logic frame_origin
);

   localparam int HTOTAL = htotal(HFP, HPULSE, HBP, HDISP);
   localparam int VTOTAL = vtotal(VFP, VPULSE, VBP, VDISP);
   localparam int HW     = $clog2(HTOTAL);
   localparam int VW     = $clog2(VTOTAL);

   localparam logic [HW-1:0] H_LAST      = HW'(HTOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_BEG  = HW'(HFP);
   localparam logic [HW-1:0] H_SYNC_END  = HW'(HFP + HPULSE);
   localparam logic [HW-1:0] H_ACT_BEG   = HW'(HTOTAL - HDISP);

   localparam logic [VW-1:0] V_LAST      = VW'(VTOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_BEG  = VW'(VFP);
   localparam logic [VW-1:0] V_SYNC_END  = VW'(VFP + VPULSE);
   localparam logic [VW-1:0] V_ACT_BEG   = VW'(VTOTAL - VDISP);

   logic [HW-1:0] hcnt_reg;
   logic [VW-1:0] vcnt_reg;
   logic          h_wrap;
   logic          hact_c;
   logic          vact_c;

   assign h_wrap = (hcnt_reg == H_LAST);

   // vcnt only advances on the horizontal wrap, so both counters wrap
   // together at the end of the last active pixel of the frame
   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hcnt_reg <= '0;
         vcnt_reg <= '0;
      end else begin
         if (h_wrap) begin
            hcnt_reg <= '0;
            if (vcnt_reg == V_LAST) begin
               vcnt_reg <= '0;
            end else begin
               vcnt_reg <= vcnt_reg + 1'b1;
            end
         end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
         end
      end
   end

   assign hsync_c      = (hcnt_reg >= H_SYNC_BEG) && (hcnt_reg < H_SYNC_END);
   assign vsync_c      = (vcnt_reg >= V_SYNC_BEG) && (vcnt_reg < V_SYNC_END);
   assign hact_c       = (hcnt_reg >= H_ACT_BEG);
   assign vact_c       = (vcnt_reg >= V_ACT_BEG);
   assign active_c     = hact_c && vact_c;
   assign first_c      = (hcnt_reg == H_ACT_BEG) && (vcnt_reg == V_ACT_BEG);
   assign frame_origin = (hcnt_reg == '0) && (vcnt_reg == '0);

endmodule

// File: rtl/vga_stream_tx.sv
// -----------------------------------------------------------------------------
// vga_stream_tx
// Pixel-side video transmitter. Pulls 24-bit pixels from a valid/ready stream
// during the active picture, generates panel sync / data-enable and drives the
// RGB output. Underflow (source not valid when a pixel is due) and a
// start-of-frame marker in the wrong place are latched as sticky flags, and
// the transmitter drops back to waiting for the next start-of-frame, which it
// locks onto at the next frame origin with no external help.
//
// Ports:
//   pixel_clk   in   pixel clock
//   sys_rst     in   asynchronous active-high reset
//   pix_data    in   pixel {R,G,B}
//   pix_sof     in   pix_data is the first pixel of a frame
//   pix_valid   in   stream valid
//   pix_ready   out  stream ready (combinational)
//   err_clr     in   clears underflow / sync_err
//   video_hs    out  horizontal sync, active-low
//   video_vs    out  vertical sync, active-low
//   video_de    out  data enable
//   video_rgb   out  output pixel, 0 outside active or when no pixel shown
//   frame_start out  one-cycle pulse with the first displayed pixel of a frame
//   underflow   out  sticky underflow flag
//   sync_err    out  sticky start-of-frame misalignment flag
// -----------------------------------------------------------------------------
module vga_stream_tx
   import video_pkg::*;
#(
   parameter int HDISP  = H_DISP_DEF,
   parameter int HFP    = H_FP_DEF,
   parameter int HPULSE = H_PULSE_DEF,
   parameter int HBP    = H_BP_DEF,
   parameter int VDISP  = V_DISP_DEF,
   parameter int VFP    = V_FP_DEF,
   parameter int VPULSE = V_PULSE_DEF,
   parameter int VBP    = V_BP_DEF
) (
   input  logic        pixel_clk,
   input  logic        sys_rst,
   input  logic [23:0] pix_data,
   input  logic        pix_sof,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic        err_clr,
   output logic        video_hs,
   output logic        video_vs,
   output logic        video_de,
   output logic [23:0] video_rgb,
   output logic        frame_start,
   output logic        underflow,
   output logic        sync_err
);

   // Position decode from the timing generator
   logic hsync_c;
   logic vsync_c;
   logic active_c;
   logic first_c;
   logic frame_origin;

   video_timing_gen #(
      .HDISP  (HDISP),
      .HFP    (HFP),
      .HPULSE (HPULSE),
      .HBP    (HBP),
      .VDISP  (VDISP),
      .VFP    (VFP),
      .VPULSE (VPULSE),
      .VBP    (VBP)
   ) u_timing (
      .pixel_clk    (pixel_clk),
      .sys_rst      (sys_rst),
      .hsync_c      (hsync_c),
      .vsync_c      (vsync_c),
      .active_c     (active_c),
      .first_c      (first_c),
      .frame_origin (frame_origin)
   );

   tx_state_e state_reg;
   tx_state_e state_next;
   rgb_t      rgb_reg;
   rgb_t      rgb_next;
   logic      hs_reg;
   logic      vs_reg;
   logic      de_reg;
   logic      fs_reg;
   logic      fs_next;
   logic      uf_reg;
   logic      uf_set;
   logic      se_reg;
   logic      se_set;

   // Stream handshake and next-state decode.
   // While waiting, everything except a start-of-frame pixel is accepted and
   // dropped, so stale data from an aborted frame drains out and the sof pixel
   // ends up parked at the head of the stream until the frame origin.
   // While streaming, a pixel is only accepted inside the active area and
   // only if its sof marker agrees with the position: the first pixel must
   // carry sof and no other pixel may. A misplaced sof pixel is left in the
   // stream so it can start the next frame.
   always_comb begin
      state_next = state_reg;
      rgb_next   = '0;
      uf_set     = 1'b0;
      se_set     = 1'b0;
      pix_ready  = 1'b0;

      if (state_reg == WAIT_SOF) begin
         pix_ready = !(pix_valid && pix_sof);
         // The sof pixel itself is not consumed here; it is taken at first_c
         if (frame_origin && pix_valid && pix_sof) begin
            state_next = STREAM;
         end
      end else begin
         if (active_c) begin
            if (!pix_valid) begin
               pix_ready  = 1'b1;
               uf_set     = 1'b1;
               state_next = WAIT_SOF;
            end else if (pix_sof != first_c) begin
               se_set     = 1'b1;
               state_next = WAIT_SOF;
            end else begin
               pix_ready  = 1'b1;
               rgb_next   = pix_data;
            end
         end
      end
   end

   assign fs_next = first_c && (state_reg == STREAM) && pix_valid && pix_sof;

   // All video outputs are registered one cycle after the counter value they
   // decode. Error flags are sticky; a new error in the same cycle as err_clr
   // keeps the flag set.
   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_reg <= WAIT_SOF;
         hs_reg    <= 1'b1;
         vs_reg    <= 1'b1;
         de_reg    <= 1'b0;
         rgb_reg   <= '0;
         fs_reg    <= 1'b0;
         uf_reg    <= 1'b0;
         se_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         hs_reg    <= !hsync_c;
         vs_reg    <= !vsync_c;
         de_reg    <= active_c;
         rgb_reg   <= rgb_next;
         fs_reg    <= fs_next;
         uf_reg    <= uf_set || (uf_reg && !err_clr);
         se_reg    <= se_set || (se_reg && !err_clr);
      end
   end

   assign video_hs    = hs_reg;
   assign video_vs    = vs_reg;
   assign video_de    = de_reg;
   assign video_rgb   = rgb_reg;
   assign frame_start = fs_reg;
   assign underflow   = uf_reg;
   assign sync_err    = se_reg;

endmodule

// File: tb/tb_vga_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_vga_stream_tx
// Self-checking bench for vga_stream_tx on a small 14x7 raster
// (HDISP=8,HFP=2,HPULSE=2,HBP=2 / VDISP=4,VFP=1,VPULSE=1,VBP=1).
// A reference model tracks the raster position as a plain cycle index since
// reset and a "locked onto a frame" bit, feeds the DUT from a pixel queue and
// compares every output on every cycle. Literal checks per scenario pin down
// the model (DE counts, captured pixel values, flag states).
// -----------------------------------------------------------------------------
module tb_vga_stream_tx;

   localparam int HT = 14;
   localparam int VT = 7;
   localparam int FT = HT * VT;   // 98 cycles per frame

   logic        pixel_clk = 1'b0;
   logic        sys_rst   = 1'b1;
   logic [23:0] pix_data  = '0;
   logic        pix_sof   = 1'b0;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic        err_clr   = 1'b0;
   logic        video_hs;
   logic        video_vs;
   logic        video_de;
   logic [23:0] video_rgb;
   logic        frame_start;
   logic        underflow;
   logic        sync_err;

   vga_stream_tx #(
      .HDISP(8), .HFP(2), .HPULSE(2), .HBP(2),
      .VDISP(4), .VFP(1), .VPULSE(1), .VBP(1)
   ) dut (
      .pixel_clk   (pixel_clk),
      .sys_rst     (sys_rst),
      .pix_data    (pix_data),
      .pix_sof     (pix_sof),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .err_clr     (err_clr),
      .video_hs    (video_hs),
      .video_vs    (video_vs),
      .video_de    (video_de),
      .video_rgb   (video_rgb),
      .frame_start (frame_start),
      .underflow   (underflow),
      .sync_err    (sync_err)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct packed {
      logic [23:0] d;
      logic        s;
   } px_t;

   px_t         src_q[$];
   logic [23:0] cap_q[$];

   int checks   = 0;
   int failures = 0;

   // model state
   int          m_pos;
   logic        m_locked;
   logic        exp_hs, exp_vs, exp_de, exp_fs, exp_uf, exp_se;
   logic [23:0] exp_rgb;

   // fault injection into the source: drop valid once when this value is due
   logic        drop_armed;
   logic [23:0] drop_data;

   // per-scenario statistics of what the DUT actually produced
   int de_cnt, hs_lo_cnt, vs_lo_cnt, fs_cnt;

   task automatic chk(input string name, input logic [23:0] act,
                      input logic [23:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic clear_stats();
      de_cnt    = 0;
      hs_lo_cnt = 0;
      vs_lo_cnt = 0;
      fs_cnt    = 0;
      cap_q.delete();
   endtask

   task automatic push_frame(input logic [23:0] base, input int n, input logic with_sof);
      for (int i = 0; i < n; i++) begin
         px_t p;
         p.d = base + 24'(i);
         p.s = with_sof && (i == 0);
         src_q.push_back(p);
      end
   endtask

   // One pixel_clk cycle. Entered just after a falling edge.
   task automatic step();
      px_t         hd;
      logic        valid;
      logic        rdy;
      logic [23:0] nxt_rgb;
      logic        fs, uf_set, se_set;
      logic        hs_lo, vs_lo, act, first, origin;
      int          h, v;

      // registered outputs against the model
      chk("video_hs",    video_hs,    exp_hs);
      chk("video_vs",    video_vs,    exp_vs);
      chk("video_de",    video_de,    exp_de);
      chk("video_rgb",   video_rgb,   exp_rgb);
      chk("frame_start", frame_start, exp_fs);
      chk("underflow",   underflow,   exp_uf);
      chk("sync_err",    sync_err,    exp_se);
      if (video_de)    cap_q.push_back(video_rgb);
      if (video_de)    de_cnt++;
      if (!video_hs)   hs_lo_cnt++;
      if (!video_vs)   vs_lo_cnt++;
      if (frame_start) fs_cnt++;

      // present the head of the source queue
      valid = 1'b0;
      hd    = '0;
      if (src_q.size() > 0) begin
         hd    = src_q[0];
         valid = 1'b1;
         if (drop_armed && hd.d == drop_data) begin
            valid      = 1'b0;
            drop_armed = 1'b0;
         end
      end
      pix_valid = valid;
      pix_data  = valid ? hd.d : 24'h0;
      pix_sof   = valid && hd.s;
      #1;

      // raster position from the cycle index
      h      = m_pos % HT;
      v      = m_pos / HT;
      hs_lo  = (h >= 2) && (h < 4);
      vs_lo  = (v == 1);
      act    = (h >= 6) && (v >= 3);
      first  = (h == 6) && (v == 3);
      origin = (m_pos == 0);

      nxt_rgb = '0;
      fs      = 1'b0;
      uf_set  = 1'b0;
      se_set  = 1'b0;
      if (!m_locked) begin
         rdy = !(valid && hd.s);
         if (origin && valid && hd.s) m_locked = 1'b1;
      end else if (!act) begin
         rdy = 1'b0;
      end else if (!valid) begin
         rdy      = 1'b1;
         uf_set   = 1'b1;
         m_locked = 1'b0;
      end else if (hd.s != first) begin
         rdy      = 1'b0;
         se_set   = 1'b1;
         m_locked = 1'b0;
      end else begin
         rdy     = 1'b1;
         nxt_rgb = hd.d;
         fs      = first;
      end

      chk("pix_ready", pix_ready, rdy);

      exp_hs  = !hs_lo;
      exp_vs  = !vs_lo;
      exp_de  = act;
      exp_rgb = nxt_rgb;
      exp_fs  = fs;
      exp_uf  = uf_set || (exp_uf && !err_clr);
      exp_se  = se_set || (exp_se && !err_clr);

      if (valid && rdy) void'(src_q.pop_front());
      m_pos = (m_pos + 1) % FT;
      @(negedge pixel_clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Asynchronous reset asserted away from any clock edge, released on a
   // falling edge. Entered just after a falling edge.
   task automatic do_reset();
      #2;
      sys_rst   = 1'b1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_data  = '0;
      err_clr   = 1'b0;
      #1;
      chk("rst_hs",  video_hs,    24'd1);
      chk("rst_vs",  video_vs,    24'd1);
      chk("rst_de",  video_de,    24'd0);
      chk("rst_rgb", video_rgb,   24'd0);
      chk("rst_fs",  frame_start, 24'd0);
      chk("rst_uf",  underflow,   24'd0);
      chk("rst_se",  sync_err,    24'd0);
      @(negedge pixel_clk);
      @(negedge pixel_clk);
      sys_rst    = 1'b0;
      m_pos      = 0;
      m_locked   = 1'b0;
      exp_hs     = 1'b1;
      exp_vs     = 1'b1;
      exp_de     = 1'b0;
      exp_rgb    = '0;
      exp_fs     = 1'b0;
      exp_uf     = 1'b0;
      exp_se     = 1'b0;
      drop_armed = 1'b0;
      drop_data  = '0;
      src_q.delete();
      clear_stats();
   endtask

   task automatic report(input string name, input int c0, input int f0);
      $display("test %s: checks=%0d failures=%0d", name, checks - c0, failures - f0);
   endtask

   initial begin
      int c0, f0;
      @(negedge pixel_clk);

      // 1) timing only, no stream
      c0 = checks; f0 = failures;
      do_reset();
      run(FT + 1);
      chk("t1_de_cycles", 24'(de_cnt),    24'd32);
      chk("t1_hs_low",    24'(hs_lo_cnt), 24'd14);
      chk("t1_vs_low",    24'(vs_lo_cnt), 24'd14);
      chk("t1_underflow", underflow,      24'd0);
      report("timing", c0, f0);

      // 2) two gapless frames
      c0 = checks; f0 = failures;
      do_reset();
      push_frame(24'h000000, 32, 1'b1);
      push_frame(24'h000100, 32, 1'b1);
      run(2 * FT + 1);
      chk("t2_de_cycles", 24'(cap_q.size()), 24'd64);
      chk("t2_fs_count",  24'(fs_cnt),       24'd2);
      chk("t2_pix0",      cap_q[0],          24'h000000);
      chk("t2_pix31",     cap_q[31],         24'h00001F);
      chk("t2_pix32",     cap_q[32],         24'h000100);
      chk("t2_pix63",     cap_q[63],         24'h00011F);
      chk("t2_flags",     {underflow, sync_err}, 24'd0);
      report("stream", c0, f0);

      // 3) stale pixels ahead of the sof frame
      c0 = checks; f0 = failures;
      do_reset();
      push_frame(24'h111100, 5, 1'b0);
      push_frame(24'hA00000, 32, 1'b1);
      run(2 * FT + 1);
      chk("t3_pix0",   cap_q[0],  24'h000000);
      chk("t3_pix32",  cap_q[32], 24'hA00000);
      chk("t3_pix63",  cap_q[63], 24'hA0001F);
      chk("t3_fs",     24'(fs_cnt), 24'd1);
      chk("t3_flags",  {underflow, sync_err}, 24'd0);
      report("stale", c0, f0);

      // 4) underflow at pixel 10, recovery, err_clr
      c0 = checks; f0 = failures;
      do_reset();
      push_frame(24'h000200, 32, 1'b1);
      push_frame(24'h000300, 32, 1'b1);
      drop_data  = 24'h00020A;
      drop_armed = 1'b1;
      run(2 * FT + 1);
      chk("t4_pix9",      cap_q[9],  24'h000209);
      chk("t4_pix10",     cap_q[10], 24'h000000);
      chk("t4_pix31",     cap_q[31], 24'h000000);
      chk("t4_pix32",     cap_q[32], 24'h000300);
      chk("t4_pix63",     cap_q[63], 24'h00031F);
      chk("t4_uf_set",    underflow, 24'd1);
      chk("t4_se_clear",  sync_err,  24'd0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      step();
      chk("t4_uf_cleared", underflow, 24'd0);
      report("underflow", c0, f0);

      // 5) sof at pixel 5
      c0 = checks; f0 = failures;
      do_reset();
      push_frame(24'h000400, 5, 1'b1);
      push_frame(24'h000500, 32, 1'b1);
      run(2 * FT + 1);
      chk("t5_pix4",    cap_q[4],  24'h000404);
      chk("t5_pix5",    cap_q[5],  24'h000000);
      chk("t5_pix32",   cap_q[32], 24'h000500);
      chk("t5_pix63",   cap_q[63], 24'h00051F);
      chk("t5_se_set",  sync_err,  24'd1);
      chk("t5_fs",      24'(fs_cnt), 24'd2);
      report("sync_err", c0, f0);

      // 6) asynchronous reset in the middle of an active line
      c0 = checks; f0 = failures;
      do_reset();
      push_frame(24'h000600, 32, 1'b1);
      run(50);
      chk("t6_pre_de",  video_de,  24'd1);
      chk("t6_pre_rgb", video_rgb, 24'h000601);
      do_reset();
      push_frame(24'h000700, 32, 1'b1);
      run(FT + 1);
      chk("t6_pix0",  cap_q[0],  24'h000700);
      chk("t6_pix31", cap_q[31], 24'h00071F);
      report("reset", c0, f0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
